// File: rtl/ps2_host_tx_pkg.sv
// Shared constants for the PS/2 host transmitter: state encoding, parameter defaults,
// command bytes and the frame parity helper.
package ps2_host_tx_pkg;

    localparam int unsigned DefInhibitCycles = 5000;    // 100 us at 50 MHz
    localparam int unsigned DefFilterLen     = 8;
    localparam int unsigned DefTimeoutCycles = 750000;  // 15 ms at 50 MHz

    localparam logic [7:0] CmdSetLeds = 8'hED;
    localparam logic [7:0] CmdReset   = 8'hFF;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StRts      = 3'd1,
        StStart    = 3'd2,
        StData     = 3'd3,
        StAck      = 3'd4,
        StWaitIdle = 3'd5
    } tx_state_e;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// 2-FF synchronizer plus FILTER_LEN-deep unanimous filter for a PS/2 line.
// level changes only when every tap agrees; fall is a one-cycle tick on the 1->0 change.
module ps2_clk_filter
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned FILTER_LEN = DefFilterLen
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic fall,
    output logic sync
);

    logic [1:0]            sync_q;
    logic [FILTER_LEN-2:0] shift_q;
    logic                  level_q;
    logic [FILTER_LEN-1:0] window;
    logic                  all_low;
    logic                  all_high;

    // The synchronizer output is the newest tap, so a change lands 2+FILTER_LEN cycles later.
    assign window   = {shift_q, sync_q[1]};
    assign all_low  = ~|window;
    assign all_high = &window;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            shift_q <= '1;
            level_q <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], raw};
            shift_q <= window[FILTER_LEN-2:0];
            if (all_low) begin
                level_q <= 1'b0;
            end else if (all_high) begin
                level_q <= 1'b1;
            end
        end
    end

    assign level = level_q;
    assign fall  = level_q & all_low;
    assign sync  = sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-clock frame and ACK check.
// Define PS2_TX_WATCHDOG_EN to build the device-clock watchdog that drives tx_err.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DefInhibitCycles,
    parameter int unsigned FILTER_LEN     = DefFilterLen,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err,
    output logic       tx_err
);

    localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);

    tx_state_e       state_q, state_d;
    logic [InhW-1:0] cnt_q, cnt_d;
    logic [3:0]      bit_q, bit_d;
    logic [8:0]      frame_q, frame_d;
    logic            ack_q, ack_d;

    logic c_level, c_fall, c_sync_unused;
    logic d_level, d_fall_unused, d_sync;

    logic c_oe_raw, d_oe_raw, done_raw;
    logic abort;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk  (clk),
        .reset(reset),
        .raw  (ps2c_in),
        .level(c_level),
        .fall (c_fall),
        .sync (c_sync_unused)
    );

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_data_filter (
        .clk  (clk),
        .reset(reset),
        .raw  (ps2d_in),
        .level(d_level),
        .fall (d_fall_unused),
        .sync (d_sync)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        frame_d  = frame_q;
        ack_d    = ack_q;
        c_oe_raw = 1'b0;
        d_oe_raw = 1'b0;
        done_raw = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wr_ps2) begin
                    frame_d = {odd_parity(din), din};
                    cnt_d   = '0;
                    state_d = StRts;
                end
            end
            StRts: begin
                c_oe_raw = 1'b1;
                d_oe_raw = 1'b1;
                if (cnt_q == InhLast) begin
                    state_d = StStart;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStart: begin
                d_oe_raw = 1'b1;
                if (c_fall) begin
                    bit_d   = 4'd0;
                    state_d = StData;
                end
            end
            StData: begin
                d_oe_raw = ~frame_q[bit_q];
                if (c_fall) begin
                    if (bit_q == 4'd8) begin
                        state_d = StAck;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            StAck: begin
                if (c_fall) begin
                    ack_d   = d_level;
                    state_d = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (c_level && d_sync) begin
                    done_raw = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            frame_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= abort ? StIdle : state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            ack_q   <= ack_d;
        end
    end

`ifdef PS2_TX_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

    logic [WdW-1:0] wd_q, wd_d;
    logic           wd_active;

    // Held at zero outside the device-clocked states, so START always begins from zero.
    always_comb begin
        wd_active = (state_q == StStart) || (state_q == StData) ||
                    (state_q == StAck) || (state_q == StWaitIdle);
        wd_d      = wd_q;
        if (!wd_active || c_fall) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + 1'b1;
        end
        abort = wd_active && !c_fall && (wd_q == WdLast);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
    assign abort = 1'b0;
`endif

    assign ps2c_oe      = c_oe_raw & ~abort;
    assign ps2d_oe      = d_oe_raw & ~abort;
    assign tx_done_tick = done_raw & ~abort;
    assign ack_err      = done_raw & ~abort & ack_q;
    assign tx_err       = abort;
    assign tx_idle      = (state_q == StIdle) | tx_done_tick | abort;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: table-driven and random transfers against an
// open-drain device model, plus reset, glitch and stalled-device sequences.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int unsigned INH  = 60;
    localparam int unsigned FLT  = 8;
    localparam int unsigned TMO  = 400;
    localparam int unsigned HALF = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_ps2;
    logic [7:0] din;
    logic       ps2c_in, ps2d_in;
    logic       ps2c_oe, ps2d_oe;
    logic       tx_idle, tx_done_tick, ack_err, tx_err;
    logic       dev_clk_low, dev_data_low;

    always #5 clk = ~clk;

    // Open-drain wired-AND with pull-ups.
    assign ps2c_in = ~(ps2c_oe | dev_clk_low);
    assign ps2d_in = ~(ps2d_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .FILTER_LEN    (FLT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .ps2c_in     (ps2c_in),
        .ps2d_in     (ps2d_in),
        .ps2c_oe     (ps2c_oe),
        .ps2d_oe     (ps2d_oe),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .ack_err     (ack_err),
        .tx_err      (tx_err)
    );

    int vec  = 0;
    int errs = 0;

    int cyc = 0;
    int done_cnt = 0, ackerr_cnt = 0, ackerr_alone = 0, txerr_cnt = 0, txerr_cyc = 0;
    int inh_run = 0, inh_last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done_tick) done_cnt <= done_cnt + 1;
        if (ack_err) ackerr_cnt <= ackerr_cnt + 1;
        if (ack_err && !tx_done_tick) ackerr_alone <= ackerr_alone + 1;
        if (tx_err) begin
            txerr_cnt <= txerr_cnt + 1;
            txerr_cyc <= cyc;
        end
        if (ps2c_oe) begin
            inh_run <= inh_run + 1;
        end else if (inh_run != 0) begin
            inh_last <= inh_run;
            inh_run  <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vec++;
        errs++;
        $display("FAIL %s: got timeout, expected event", name);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference frame as seen on the wire: [0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    // Device side: waits for request-to-send, then clocks 11 pulses, sampling data on
    // each rising edge. Returns early (clock left high) after falling edge stop_after.
    task automatic device(input int stop_after, input bit do_ack, input bit glitch,
                          output logic [10:0] seen, output int fall_cyc);
        int n;
        seen     = '0;
        fall_cyc = 0;
        n = 0;
        while (ps2c_in !== 1'b0 && n < 50) begin
            tick(1);
            n++;
        end
        if (ps2c_in !== 1'b0) begin
            timeout("rts_inhibit");
            return;
        end
        n = 0;
        while (!(ps2c_in === 1'b1 && ps2d_in === 1'b0) && n < 4 * INH) begin
            tick(1);
            n++;
        end
        if (!(ps2c_in === 1'b1 && ps2d_in === 1'b0)) begin
            timeout("rts_release");
            return;
        end
        tick(HALF);
        seen[0] = ps2d_in;
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            fall_cyc    = cyc;
            tick(HALF);
            dev_clk_low = 1'b0;
            if (k <= 10) seen[k] = ps2d_in;
            if (k == stop_after) return;
            if (k == 3 && glitch) begin
                tick(10);
                dev_clk_low = 1'b1;
                tick(3);
                dev_clk_low = 1'b0;
                tick(5);
                wr_ps2 = 1'b1;
                din    = 8'h55;
                tick(1);
                wr_ps2 = 1'b0;
                tick(HALF - 19);
            end else if (k == 10 && do_ack) begin
                tick(4);
                dev_data_low = 1'b1;
                tick(HALF - 4);
            end else if (k == 11) begin
                tick(4);
                dev_data_low = 1'b0;
                tick(HALF - 4);
            end else begin
                tick(HALF);
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        wr_ps2 = 1'b1;
        din    = b;
        tick(1);
        wr_ps2 = 1'b0;
        check("idle_fall", tx_idle, 1'b0);
    endtask

    task automatic xfer(input logic [7:0] b, input bit do_ack, input bit glitch,
                        input logic exp_par, input logic exp_ack_err);
        logic [10:0] seen;
        int          lf;
        int          d0, a0, n;
        d0 = done_cnt;
        a0 = ackerr_cnt;
        send(b);
        device(99, do_ack, glitch, seen, lf);
        check("frame", seen, model_frame(b));
        check("parity", seen[9], exp_par);
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            tick(1);
            n++;
        end
        if (done_cnt == d0) timeout("done_tick");
        tick(2);
        check("done_count", done_cnt - d0, 1);
        check("ack_err", ackerr_cnt - a0, exp_ack_err);
        check("idle_after", tx_idle, 1'b1);
        check("inhibit_len", inh_last, INH);
    endtask

    typedef struct {
        logic [7:0] b;
        bit         ack;
        bit         glitch;
        logic       exp_par;
        logic       exp_ack_err;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [10:0] seen;
        int          lf, t0, d0, n;

        tbl[0] = '{b: CmdSetLeds, ack: 1'b1, glitch: 1'b0, exp_par: 1'b1, exp_ack_err: 1'b0};
        tbl[1] = '{b: 8'h01,      ack: 1'b1, glitch: 1'b0, exp_par: 1'b0, exp_ack_err: 1'b0};
        tbl[2] = '{b: 8'h00,      ack: 1'b1, glitch: 1'b0, exp_par: 1'b1, exp_ack_err: 1'b0};
        tbl[3] = '{b: 8'hA5,      ack: 1'b0, glitch: 1'b0, exp_par: 1'b1, exp_ack_err: 1'b1};
        tbl[4] = '{b: 8'h3C,      ack: 1'b1, glitch: 1'b1, exp_par: 1'b1, exp_ack_err: 1'b0};

        reset        = 1'b0;
        wr_ps2       = 1'b0;
        din          = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        tick(3);
        check("rst_ps2c_oe", ps2c_oe, 1'b0);
        check("rst_ps2d_oe", ps2d_oe, 1'b0);
        check("rst_tx_idle", tx_idle, 1'b1);
        check("rst_done", tx_done_tick, 1'b0);
        check("rst_tx_err", tx_err, 1'b0);
        reset = 1'b1;
        tick(5);

        for (int i = 0; i < 5; i++) begin
            xfer(tbl[i].b, tbl[i].ack, tbl[i].glitch, tbl[i].exp_par, tbl[i].exp_ack_err);
        end

        // Reset in the middle of the data phase.
        send(8'h96);
        device(4, 1'b1, 1'b0, seen, lf);
        check("mid_busy", tx_idle, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        check("async_ps2c_oe", ps2c_oe, 1'b0);
        check("async_ps2d_oe", ps2d_oe, 1'b0);
        check("async_tx_idle", tx_idle, 1'b1);
        tick(2);
        reset = 1'b1;
        tick(3);
        xfer(CmdReset, 1'b1, 1'b0, 1'b1, 1'b0);

        // Device stalls after four falling edges.
        t0 = txerr_cnt;
        d0 = done_cnt;
        send(8'h5A);
        device(4, 1'b1, 1'b0, seen, lf);
`ifdef PS2_TX_WATCHDOG_EN
        n = 0;
        while (txerr_cnt == t0 && n < int'(TMO) + 200) begin
            tick(1);
            n++;
        end
        if (txerr_cnt == t0) timeout("tx_err");
        check("wd_latency", (txerr_cyc - lf >= int'(TMO)) &&
                            (txerr_cyc - lf <= int'(TMO + FLT) + 4), 1'b1);
        check("wd_ps2c_oe", ps2c_oe, 1'b0);
        check("wd_ps2d_oe", ps2d_oe, 1'b0);
        check("wd_tx_idle", tx_idle, 1'b1);
        check("wd_no_done", done_cnt - d0, 0);
`else
        n = 0;
        tick(TMO + FLT + 50);
        check("stall_no_err", txerr_cnt - t0, n);
        check("stall_busy", tx_idle, 1'b0);
        check("stall_no_done", done_cnt - d0, 0);
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(3);
`endif

        for (int i = 0; i < 5; i++) begin
            logic [7:0] rb;
            bit         rack;
            logic [10:0] ref_frame;
            rb        = 8'($urandom_range(0, 255));
            rack      = ($urandom_range(0, 3) != 0);
            ref_frame = model_frame(rb);
            xfer(rb, rack, 1'b0, ref_frame[9], !rack);
        end

        check("ack_err_alone", ackerr_alone, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
